// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // What the FIFO does on a given edge, encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Address width needed to index 'depth' entries (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the word on an accepted write.
    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
    // its contents are meaningless until written, and the pointers guarantee that.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            // NOTE: sequential state always uses <= so every flop samples pre-edge values;
            // that is also what makes a same-edge read of this address return the old word.
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: load the addressed word on an accepted read, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : fifo_mem

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: pointer/count control, status flags and sticky error flags
// around a fifo_mem storage block. Read data appears one cycle after the request.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    read_en,
    input  logic                    clr_err,
    output logic [DATA_W-1:0]       data_out,
    output logic                    data_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [addr_w(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = addr_w(DEPTH);

    localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_THR = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_THR = AE_LEVEL[AW:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        rd_acc;
    logic        wr_acc;
    fifo_op_e    op;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A write into a full FIFO is still fine when a read frees the slot on the same edge.
    assign rd_acc = read_en && !empty;
    assign wr_acc = write_en && (!full || rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (data_out)
    );

    // Advance each pointer only on its accepted operation; rejected requests change nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
        end
    end

    // Occupancy tracks the net effect of the accepted operations on this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case (op)
                OP_WRITE: count <= count + ONE;
                OP_READ:  count <= count - ONE;
                default:  count <= count;
            endcase
        end
    end

    // data_valid marks the single cycle in which a freshly read word sits on data_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
        end
    end

    // Sticky error flags: a new error on the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (write_en && !wr_acc) || (overflow  && !clr_err);
            underflow <= (read_en  && empty)   || (underflow && !clr_err);
        end
    end

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (DATA_W=8, DEPTH=16): stimulus pushes expected
// read data into a queue, a negedge monitor pops and compares on every data_valid.
module tb_param_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              write_en = 1'b0;
    logic              read_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [4:0]        count;
    logic              overflow;
    logic              underflow;

    param_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .data_in      (data_in),
        .read_en      (read_en),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                m_ovf = 1'b0;
    bit                m_udf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags derived from the reference occupancy and reference error state.
    task automatic check_status(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".count"},        count,        n);
        check({tag, ".full"},         full,         n == DEPTH);
        check({tag, ".empty"},        empty,        n == 0);
        check({tag, ".almost_full"},  almost_full,  n >= DEPTH - 2);
        check({tag, ".almost_empty"}, almost_empty, n <= 2);
        check({tag, ".overflow"},     overflow,     m_ovf);
        check({tag, ".underflow"},    underflow,    m_udf);
    endtask

    // Issue one cycle of requests; inputs change 1 time unit after the rising edge.
    task automatic do_op(input bit wr, input logic [DATA_W-1:0] d, input bit rd, input bit clr);
        int n;
        bit rd_ok;
        bit wr_ok;
        n     = model_q.size();
        rd_ok = rd && (n > 0);
        wr_ok = wr && ((n < DEPTH) || rd_ok);
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
        m_udf = (rd && (n == 0)) || (m_udf && !clr);
        write_en = wr;
        data_in  = d;
        read_en  = rd;
        clr_err  = clr;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        clr_err  = 1'b0;
        check("data_valid", data_valid, rd_ok);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".count"},        count,        0);
        check({tag, ".empty"},        empty,        1);
        check({tag, ".full"},         full,         0);
        check({tag, ".almost_empty"}, almost_empty, 1);
        check({tag, ".almost_full"},  almost_full,  0);
        check({tag, ".data_valid"},   data_valid,   0);
        check({tag, ".data_out"},     data_out,     0);
        check({tag, ".overflow"},     overflow,     0);
        check({tag, ".underflow"},    underflow,    0);
    endtask

    // Monitor: every data_valid cycle must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_out 0x%0h, expected no valid", data_out);
            end else begin
                check("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state while reset is held low.
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fill 0x01..0x10; the first write lands on the first edge after release.
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(1'b1, 8'(i), 1'b0, 1'b0);
            check_status("fill");
        end
        check("fill.full_const",     full,     1);
        check("fill.count_const",    count,    16);
        check("fill.overflow_const", overflow, 0);

        // Write while full: rejected, overflow sticky, then cleared.
        do_op(1'b1, 8'hAA, 1'b0, 1'b0);
        check_status("ovf");
        check("ovf.flag_const", overflow, 1);
        do_op(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf.sticky", overflow, 1);
        do_op(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf.cleared", overflow, 0);

        // Read and write together while full.
        do_op(1'b1, 8'h55, 1'b1, 1'b0);
        check_status("rw_full");
        check("rw_full.data_out_const", data_out, 8'h01);
        check("rw_full.count_const",    count,    16);

        // Drain: expect 0x02..0x10 then 0x55.
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1'b0, 8'h00, 1'b1, 1'b0);
            check_status("drain");
        end
        check("drain.last_const", data_out, 8'h55);

        // Read on empty, then read+write together on empty.
        do_op(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("udf");
        check("udf.flag_const", underflow, 1);
        do_op(1'b1, 8'h77, 1'b1, 1'b0);
        check_status("rw_empty");
        check("rw_empty.count_const", count, 1);
        do_op(1'b0, 8'h00, 1'b1, 1'b1);
        check_status("udf_clear");
        // Underflow on the same edge as the clear: set wins.
        do_op(1'b0, 8'h00, 1'b1, 1'b1);
        check("udf.set_wins", underflow, 1);
        do_op(1'b0, 8'h00, 1'b0, 1'b1);
        check_status("udf_clear2");

        // Pointer wrap: keep 3 words in flight over 40 simultaneous write/read pairs.
        for (int i = 0; i < 3; i++) do_op(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 3; i < 43; i++) begin
            do_op(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            check_status("wrap");
        end
        for (int i = 0; i < 3; i++) do_op(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("wrap_drained");
        // Full and empty detection with pointers sitting at a wrapped offset.
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1'b1, 8'(i * 3 + 1), 1'b0, 1'b0);
            check_status("wrap_fill");
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1'b0, 8'h00, 1'b1, 1'b0);
            check_status("wrap_drain");
        end

        // Asynchronous reset with 7 words stored and error flag set.
        do_op(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) do_op(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        do_op(1'b0, 8'h00, 1'b1, 1'b0);
        do_op(1'b0, 8'h00, 1'b0, 1'b0);
        check_status("pre_reset");
        check("pre_reset.count_const", count, 7);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_op(1'b0, 8'h00, 1'b1, 1'b0);
        check_status("post_reset");
        check("post_reset.underflow_const", underflow, 1);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard.drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_param_sync_fifo

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of entries; a power of two, at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2: occupancy at or below which almost_empty asserts.
REQ-005 clk  in  1: single clock; all state updates on the rising edge.
REQ-006 reset  in  1: asynchronous, active-low reset.
REQ-007 write_en  in  1: write request.
REQ-008 data_in  in  DATA_W: write data.
REQ-009 read_en  in  1: read request.
REQ-010 clr_err  in  1: synchronous clear of the sticky overflow and underflow flags.
REQ-011 data_out  out  DATA_W: read data, registered.
REQ-012 data_valid  out  1: one-cycle pulse marking data_out valid.
REQ-013 full, empty  out  1 each: occupancy equals DEPTH / occupancy equals 0.
REQ-014 almost_full, almost_empty  out  1 each: threshold flags per REQ-003 and REQ-004.
REQ-015 count  out  clog2(DEPTH)+1: current occupancy.
REQ-016 overflow, underflow  out  1 each: sticky error flags.

Function
REQ-017 Read acceptance: a read SHALL be accepted iff read_en=1 and empty=0.
REQ-018 Write acceptance: a write SHALL be accepted iff write_en=1 and (full=0 or the read is accepted in the same cycle).
REQ-019 Accepted write: data_in is stored at wr_ptr, and wr_ptr increments modulo 2*DEPTH (one extra wrap bit).
REQ-020 Accepted read: the word at rd_ptr is loaded into data_out on that edge, data_valid=1 for exactly that following cycle, and rd_ptr increments modulo 2*DEPTH.
REQ-021 Read latency: one cycle; there is no fall-through on an empty FIFO.
REQ-022 Hold: data_out SHALL hold its last value when no read is accepted.
REQ-023 count SHALL change per edge by +1 (write only), -1 (read only), or 0 (both accepted or neither).
REQ-024 full=1 iff the pointer address bits are equal and the wrap bits differ; empty=1 iff the pointers are fully equal; both are derived combinationally from registered pointers.
REQ-025 almost_full=(count>=AF_LEVEL) and almost_empty=(count<=AE_LEVEL), combinational from count.
REQ-026 Simultaneous read and write when full: both accepted; count stays DEPTH; no overflow.
REQ-027 Simultaneous read and write when empty: write accepted, read rejected, underflow set; count becomes 1.
REQ-028 overflow SHALL set on any edge where write_en=1 and the write is rejected.
REQ-029 underflow SHALL set on any edge where read_en=1 and empty=1.
REQ-030 Both error flags SHALL stay set until clr_err=1 or reset; when set and clear coincide on the same edge, set wins.
REQ-031 Rejected operations SHALL alter neither storage, pointers nor count.

Reset
REQ-032 reset=0 SHALL immediately clear wr_ptr, rd_ptr, count, data_out, data_valid, overflow and underflow, giving empty=1, full=0, almost_empty=1, almost_full=0.
REQ-033 Reset asserted mid-operation SHALL discard all contents; storage array contents are not reset and are don't-care.
REQ-034 Deassertion of reset is synchronous to clk; the first request is honoured on the first rising edge after deassertion.

Structure
REQ-035 Package fifo_pkg SHALL hold the clog2-based address-width function and the default DATA_W/DEPTH constants.
REQ-036 Storage SHALL be a sub-module fifo_mem: a DEPTH x DATA_W array with a synchronous write port and a synchronous read port.
REQ-037 Control (pointers, count, flags) SHALL reside in param_sync_fifo; target size is 120-400 RTL lines.

Verification
REQ-038 Reset, then write 0x01..0x10 (DEPTH=16) -> full=1, count=16, almost_full asserted at count=14, no overflow.
REQ-039 While full, write 0xAA alone -> overflow=1 sticky, count=16, contents unchanged; then clr_err -> overflow=0.
REQ-040 While full, read and write 0x55 together -> data_out=0x01 with data_valid next cycle, count=16; draining 16 reads yields 0x02..0x10, 0x55.
REQ-041 While empty, read alone -> underflow=1, data_valid=0; read and write 0x77 together -> count=1, underflow stays set.
REQ-042 Perform 40 interleaved write/read pairs to wrap the pointers twice -> output order equals input order, and full/empty are correct at every wrap.
REQ-043 Assert reset=0 asynchronously with count=7 -> all outputs at reset values before the next clk edge; a subsequent read gives underflow.
